// File: rtl/world_camera_transformer_pkg.sv
// Shared Q16.16 math, vertex/triangle and camera types for the world-to-camera transformer.
// Optional behind-camera culling is enabled by defining WORLD_CAMERA_CULL_BEHIND_EN.
package world_camera_transformer_pkg;

    localparam int unsigned COORD_W = 32;
    localparam int unsigned FRAC_W  = 16;
    localparam int unsigned COLOR_W = 32;
    localparam int unsigned ACC_W   = 2 * COORD_W + 2;

    typedef logic signed [COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
        coord_t z;
    } vec3_t;

    typedef struct packed {
        vec3_t row0;
        vec3_t row1;
        vec3_t row2;
    } matrix_t;

    typedef struct packed {
        vec3_t              pos;
        logic [COLOR_W-1:0] color;
    } vertex_t;

    typedef struct packed {
        vertex_t v0;
        vertex_t v1;
        vertex_t v2;
    } triangle_t;

    typedef struct packed {
        vec3_t   pos;
        matrix_t rot_mtx;
    } camera_t;

    typedef struct packed {
        triangle_t triangle;
        camera_t   camera;
    } world_camera_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
        vec3_t      pos;
    } pipe_item_t;

    function automatic logic signed [2*COORD_W-1:0] mul_transform(input coord_t a, input coord_t b);
        return (2*COORD_W)'(a) * (2*COORD_W)'(b);
    endfunction

    // Exact three-term sum, round half toward +inf, keep the low 32 bits of the Q16.16 result.
    function automatic coord_t dot3_transform(input vec3_t row, input coord_t x, input coord_t y,
                                              input coord_t z);
        logic signed [ACC_W-1:0] acc;
        acc = ACC_W'(mul_transform(row.x, x))
            + ACC_W'(mul_transform(row.y, y))
            + ACC_W'(mul_transform(row.z, z))
            + (ACC_W'(1) <<< (FRAC_W - 1));
        return acc[FRAC_W+COORD_W-1:FRAC_W];
    endfunction

endpackage

// File: rtl/world_camera_transformer_pipe.sv
// Two-stage camera transform pipe: T subtracts the camera position, R applies the rotation.
// Valid and vertex index travel alongside the data as sideband.
module camera_vertex_pipe
    import world_camera_transformer_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       valid_i,
    input  logic [1:0] idx_i,
    input  vec3_t      pos_i,
    input  camera_t    camera_i,
    output logic       valid_o,
    output logic [1:0] idx_o,
    output vec3_t      pos_o
);

    pipe_item_t t_d, t_q;
    pipe_item_t r_d, r_q;

    // Next-state for both stages; subtraction wraps in 32 bits.
    always_comb begin
        t_d.valid = valid_i;
        t_d.idx   = idx_i;
        t_d.pos.x = pos_i.x - camera_i.pos.x;
        t_d.pos.y = pos_i.y - camera_i.pos.y;
        t_d.pos.z = pos_i.z - camera_i.pos.z;

        r_d.valid = t_q.valid;
        r_d.idx   = t_q.idx;
        r_d.pos.x = dot3_transform(camera_i.rot_mtx.row0, t_q.pos.x, t_q.pos.y, t_q.pos.z);
        r_d.pos.y = dot3_transform(camera_i.rot_mtx.row1, t_q.pos.x, t_q.pos.y, t_q.pos.z);
        r_d.pos.z = dot3_transform(camera_i.rot_mtx.row2, t_q.pos.x, t_q.pos.y, t_q.pos.z);
    end

    // Stage registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            t_q <= '0;
            r_q <= '0;
        end else begin
            t_q <= t_d;
            r_q <= r_d;
        end
    end

    assign valid_o = r_q.valid;
    assign idx_o   = r_q.idx;
    assign pos_o   = r_q.pos;

endmodule

// File: rtl/world_camera_transformer.sv
// World-to-camera transformer stage: FSM, vertex issue counter and triangle writeback.
// Define WORLD_CAMERA_CULL_BEHIND_EN to drop triangles whose camera-space z are all <= NEAR_Z.
module world_camera_transformer
    import world_camera_transformer_pkg::*;
#(
    parameter logic signed [31:0] NEAR_Z = 32'sd0
) (
    input  logic          clk,
    input  logic          rst,
    input  world_camera_t world_camera,
    input  logic          in_valid,
    output logic          in_ready,
    output triangle_t     out_triangle,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy
);

`ifdef WORLD_CAMERA_CULL_BEHIND_EN
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PROCESS = 2'd1,
        ST_DONE    = 2'd2,
        ST_CULL    = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PROCESS = 2'd1,
        ST_DONE    = 2'd2
    } state_t;
`endif

    state_t     state_d, state_q;
    triangle_t  tri_d, tri_q;
    camera_t    cam_d, cam_q;
    logic [1:0] cnt_d, cnt_q;

    logic       issue_valid_s;
    vec3_t      issue_pos_s;
    logic       wb_valid_s;
    logic [1:0] wb_idx_s;
    vec3_t      wb_pos_s;
    logic       last_wb_s;

    assign issue_valid_s = (state_q == ST_PROCESS) && (cnt_q != 2'd3);
    assign last_wb_s     = wb_valid_s && (wb_idx_s == 2'd2);

`ifdef WORLD_CAMERA_CULL_BEHIND_EN
    logic all_behind_s;
    // v0/v1 are already written back; v2 is still on the pipe output.
    assign all_behind_s = ($signed(tri_q.v0.pos.z) <= NEAR_Z)
                       && ($signed(tri_q.v1.pos.z) <= NEAR_Z)
                       && ($signed(wb_pos_s.z) <= NEAR_Z);
`endif

    // Select the world-space vertex addressed by the issue counter.
    always_comb begin
        issue_pos_s = '0;
        case (cnt_q)
            2'd0:    issue_pos_s = tri_q.v0.pos;
            2'd1:    issue_pos_s = tri_q.v1.pos;
            2'd2:    issue_pos_s = tri_q.v2.pos;
            default: issue_pos_s = '0;
        endcase
    end

    camera_vertex_pipe u_pipe (
        .clk_i    (clk),
        .rst_i    (rst),
        .valid_i  (issue_valid_s),
        .idx_i    (cnt_q),
        .pos_i    (issue_pos_s),
        .camera_i (cam_q),
        .valid_o  (wb_valid_s),
        .idx_o    (wb_idx_s),
        .pos_o    (wb_pos_s)
    );

    // Next-state: FSM transitions, input capture, issue counter and vertex writeback.
    always_comb begin
        state_d = state_q;
        tri_d   = tri_q;
        cam_d   = cam_q;
        cnt_d   = cnt_q;

        if (wb_valid_s) begin
            case (wb_idx_s)
                2'd0:    tri_d.v0.pos = wb_pos_s;
                2'd1:    tri_d.v1.pos = wb_pos_s;
                2'd2:    tri_d.v2.pos = wb_pos_s;
                default: tri_d = tri_q;
            endcase
        end else begin
            tri_d = tri_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_PROCESS;
                    tri_d   = world_camera.triangle;
                    cam_d   = world_camera.camera;
                    cnt_d   = 2'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PROCESS: begin
                if (cnt_q != 2'd3) begin
                    cnt_d = cnt_q + 2'd1;
                end else begin
                    cnt_d = cnt_q;
                end
`ifdef WORLD_CAMERA_CULL_BEHIND_EN
                if (last_wb_s) begin
                    if (all_behind_s) begin
                        state_d = ST_CULL;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_PROCESS;
                end
`else
                if (last_wb_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_PROCESS;
                end
`endif
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
`ifdef WORLD_CAMERA_CULL_BEHIND_EN
            ST_CULL: state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // State and data registers; reset aborts any triangle in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tri_q   <= '0;
            cam_q   <= '0;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            tri_q   <= tri_d;
            cam_q   <= cam_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready     = (state_q == ST_IDLE);
    assign out_valid    = (state_q == ST_DONE);
    assign busy         = (state_q != ST_IDLE);
    assign out_triangle = tri_q;

endmodule

// File: tb/tb_world_camera_transformer.sv
// Randomized + directed scoreboard bench for world_camera_transformer.
`timescale 1ns/1ps
module tb_world_camera_transformer;
    import world_camera_transformer_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    world_camera_t world_camera;
    logic          in_valid;
    logic          in_ready;
    triangle_t     out_triangle;
    logic          out_valid;
    logic          out_ready;
    logic          busy;

    always #5 clk = ~clk;

    world_camera_transformer dut (
        .clk          (clk),
        .rst          (rst),
        .world_camera (world_camera),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_triangle (out_triangle),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc_count = 0;
    int out_count = 0;
    int last_acc_cyc = 0;
    int acc_hist[$];
    int hs_hist[$];
    world_camera_t stim_q[$];
    triangle_t     exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic coord_t model_axis(vec3_t row, vec3_t t);
        logic signed [127:0] rx, ry, rz, tx, ty, tz, s;
        rx = $signed(row.x); ry = $signed(row.y); rz = $signed(row.z);
        tx = $signed(t.x);   ty = $signed(t.y);   tz = $signed(t.z);
        s = rx * tx + ry * ty + rz * tz + 128'sd32768;
        s = s >>> 16;
        return s[31:0];
    endfunction

    function automatic vec3_t model_vertex(vec3_t p, camera_t c);
        vec3_t t, r;
        t.x = p.x - c.pos.x;
        t.y = p.y - c.pos.y;
        t.z = p.z - c.pos.z;
        r.x = model_axis(c.rot_mtx.row0, t);
        r.y = model_axis(c.rot_mtx.row1, t);
        r.z = model_axis(c.rot_mtx.row2, t);
        return r;
    endfunction

    function automatic triangle_t model_triangle(world_camera_t wc);
        triangle_t r;
        r = wc.triangle;
        r.v0.pos = model_vertex(wc.triangle.v0.pos, wc.camera);
        r.v1.pos = model_vertex(wc.triangle.v1.pos, wc.camera);
        r.v2.pos = model_vertex(wc.triangle.v2.pos, wc.camera);
        return r;
    endfunction

    function automatic bit model_emits(world_camera_t wc);
`ifdef WORLD_CAMERA_CULL_BEHIND_EN
        triangle_t r;
        r = model_triangle(wc);
        return !(($signed(r.v0.pos.z) <= 0) && ($signed(r.v1.pos.z) <= 0) && ($signed(r.v2.pos.z) <= 0));
`else
        return 1'b1;
`endif
    endfunction

    // ---------------- stimulus helpers ----------------
    function automatic vec3_t v3(int x, int y, int z);
        vec3_t r;
        r.x = x * 65536;
        r.y = y * 65536;
        r.z = z * 65536;
        return r;
    endfunction

    function automatic matrix_t ident();
        matrix_t m;
        m.row0 = v3(1, 0, 0);
        m.row1 = v3(0, 1, 0);
        m.row2 = v3(0, 0, 1);
        return m;
    endfunction

    function automatic world_camera_t mk_wc(vec3_t p0, vec3_t p1, vec3_t p2, vec3_t cp, matrix_t m, int tag);
        world_camera_t wc;
        wc.triangle.v0.pos = p0; wc.triangle.v0.color = 32'hC000_0000 + 32'(tag * 3);
        wc.triangle.v1.pos = p1; wc.triangle.v1.color = 32'hC000_0001 + 32'(tag * 3);
        wc.triangle.v2.pos = p2; wc.triangle.v2.color = 32'hC000_0002 + 32'(tag * 3);
        wc.camera.pos = cp;
        wc.camera.rot_mtx = m;
        return wc;
    endfunction

    function automatic coord_t rnd_q(int unsigned span);
        int v;
        v = int'($urandom_range(0, 2 * span)) - int'(span);
        return v;
    endfunction

    // ---------------- checkers ----------------
    task automatic chk_int(string name, int got, int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic chk_tri(string name, triangle_t got, triangle_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    initial begin
        in_valid = 1'b0;
        world_camera = '0;
        forever begin
            @(posedge clk); #2;
            if (stim_q.size() > 0) begin
                world_camera = stim_q[0];
                in_valid = 1'b1;
                if (in_ready && !rst) begin
                    last_acc_cyc = cyc;
                    acc_hist.push_back(cyc);
                    acc_count++;
                    if (model_emits(stim_q[0])) exp_q.push_back(model_triangle(stim_q[0]));
                    void'(stim_q.pop_front());
                end
            end else begin
                in_valid = 1'b0;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        triangle_t held;
        logic prev_stall, prev_ov;
        held = '0; prev_stall = 1'b0; prev_ov = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (out_valid && !prev_ov) chk_int("latency", cyc - last_acc_cyc, 6);
                if (out_valid && prev_stall) chk_tri("hold_stable", out_triangle, held);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_output got=%h expected=none", out_triangle);
                    end else begin
                        chk_tri("triangle", out_triangle, exp_q.pop_front());
                    end
                    hs_hist.push_back(cyc);
                    out_count++;
                end
                prev_stall = out_valid && !out_ready;
                prev_ov = out_valid;
                held = out_triangle;
            end else begin
                prev_stall = 1'b0;
                prev_ov = 1'b0;
            end
        end
    end

    task automatic tick(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_outs(int target, int budget);
        int k;
        k = 0;
        while (out_count < target && k < budget) begin tick(1); k++; end
        if (out_count < target) chk_int("output_timeout", out_count, target);
    endtask

    task automatic wait_accept(int target, int budget);
        int k;
        k = 0;
        while (acc_count < target && k < budget) begin tick(1); k++; end
        if (acc_count < target) chk_int("accept_timeout", acc_count, target);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        matrix_t rot;
        int tgt, k;
        rst = 1'b1;
        out_ready = 1'b1;
        tick(3);
        rst = 1'b0;
        @(negedge clk);
        chk_int("reset_in_ready", int'(in_ready), 1);
        chk_int("reset_out_valid", int'(out_valid), 0);
        chk_int("reset_busy", int'(busy), 0);
        chk_int("reset_out_triangle_zero", int'(out_triangle == '0), 1);
        tick(1);

        // identity rotation, translated camera
        stim_q.push_back(mk_wc(v3(4, 4, 4), v3(0, 0, 0), v3(-1, 5, 3), v3(1, 2, 3), ident(), 1));
        wait_outs(1, 60);

        // 90-degree rotation about z
        rot.row0 = v3(0, 1, 0); rot.row1 = v3(-1, 0, 0); rot.row2 = v3(0, 0, 1);
        stim_q.push_back(mk_wc(v3(1, 0, 0), v3(0, 2, 0), v3(0, 0, 5), v3(0, 0, 0), rot, 2));
        wait_outs(2, 60);

        // backpressure: hold DONE while the next triangle is offered
        out_ready = 1'b0;
        stim_q.push_back(mk_wc(v3(2, 3, 4), v3(5, 6, 7), v3(8, 9, 10), v3(1, 1, 1), ident(), 3));
        stim_q.push_back(mk_wc(v3(-3, 7, 2), v3(6, -2, 9), v3(1, 1, 1), v3(0, 1, 0), rot, 4));
        k = 0;
        do begin @(negedge clk); k++; end while (!out_valid && k < 40);
        chk_int("stall_reached_done", int'(out_valid), 1);
        for (int i = 0; i < 10; i++) begin
            chk_int("stall_out_valid", int'(out_valid), 1);
            chk_int("stall_in_ready", int'(in_ready), 0);
            chk_int("stall_busy", int'(busy), 1);
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk_int("after_accept_in_ready", int'(in_ready), 1);
        wait_outs(4, 60);
        chk_int("next_accept_after_hs", acc_hist[3], hs_hist[2] + 1);

        // back-to-back with in_valid held
        stim_q.push_back(mk_wc(v3(7, -1, 2), v3(3, 3, 3), v3(-4, 0, 6), v3(2, 0, 1), ident(), 5));
        stim_q.push_back(mk_wc(v3(1, 2, 3), v3(4, 5, 6), v3(7, 8, 9), v3(-1, -1, -1), rot, 6));
        wait_outs(6, 80);
        chk_int("b2b_accept_after_hs", acc_hist[5], hs_hist[4] + 1);

        // reset in PROCESS cycle c4, then a fresh triangle
        tgt = acc_count + 1;
        stim_q.push_back(mk_wc(v3(9, 9, 9), v3(8, 8, 8), v3(7, 7, 7), v3(0, 0, 0), rot, 7));
        wait_accept(tgt, 20);
        tick(3);
        rst = 1'b1;
        void'(exp_q.pop_back());
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        chk_int("midrst_in_ready", int'(in_ready), 1);
        chk_int("midrst_out_valid", int'(out_valid), 0);
        chk_int("midrst_busy", int'(busy), 0);
        tgt = out_count + 1;
        stim_q.push_back(mk_wc(v3(-2, 1, 4), v3(3, -5, 2), v3(6, 6, -1), v3(1, 0, -1), ident(), 8));
        wait_outs(tgt, 60);

`ifdef WORLD_CAMERA_CULL_BEHIND_EN
        tgt = acc_count + 1;
        stim_q.push_back(mk_wc(v3(0, 0, -1), v3(1, 0, -1), v3(0, 1, -1), v3(0, 0, 0), ident(), 9));
        wait_accept(tgt, 20);
        tick(5);
        @(negedge clk);
        chk_int("cull_c6_busy", int'(busy), 1);
        chk_int("cull_c6_out_valid", int'(out_valid), 0);
        @(negedge clk);
        chk_int("cull_c7_busy", int'(busy), 0);
        tgt = out_count + 1;
        stim_q.push_back(mk_wc(v3(0, 0, -1), v3(1, 0, -1), vec3_t'({32'sd0, 32'sd65536, 32'sd32768}),
                               v3(0, 0, 0), ident(), 10));
        wait_outs(tgt, 60);
`endif

        // randomized traffic with random downstream stalls
        tgt = out_count;
        for (int i = 0; i < 20; i++) begin
            world_camera_t wc;
            wc.triangle.v0.pos = {32'($urandom), 32'($urandom), 32'($urandom)};
            wc.triangle.v1.pos = {rnd_q(32'd4000000), rnd_q(32'd4000000), rnd_q(32'd4000000)};
            wc.triangle.v2.pos = {32'($urandom), rnd_q(32'd100000), 32'($urandom)};
            wc.triangle.v0.color = $urandom;
            wc.triangle.v1.color = $urandom;
            wc.triangle.v2.color = $urandom;
            wc.camera.pos = {rnd_q(32'd2000000), 32'($urandom), rnd_q(32'd2000000)};
            wc.camera.rot_mtx.row0 = {rnd_q(32'd131072), rnd_q(32'd131072), rnd_q(32'd131072)};
            wc.camera.rot_mtx.row1 = {rnd_q(32'd131072), 32'($urandom), rnd_q(32'd131072)};
            wc.camera.rot_mtx.row2 = {rnd_q(32'd131072), rnd_q(32'd131072), rnd_q(32'd131072)};
            if (model_emits(wc)) tgt++;
            stim_q.push_back(wc);
        end
        k = 0;
        while ((out_count < tgt || stim_q.size() > 0) && k < 3000) begin
            out_ready = 1'($urandom_range(0, 1));
            tick(1);
            k++;
        end
        out_ready = 1'b1;
        tick(10);
        chk_int("random_outputs", out_count, tgt);
        chk_int("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
